// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multicycle multiply/divide unit.
package mult_div_unit_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StDz   = 3'd3,
    StFix  = 3'd4,
    StDone = 3'd5
  } state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Combinational conditional two's-complement negate; with neg_i tied to the MSB it yields |val_i|.
module mult_div_unit_sign_fix #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] val_i,
  input  logic             neg_i,
  output logic [Width-1:0] val_o
);

  assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit, one bit per cycle on operand magnitudes, with a final
// sign-fix cycle. Optional MDU_EARLY_EXIT_EN: multiply leaves the iteration loop as soon as the
// remaining multiplier bits are all zero.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             CtoM,
  input  logic             CtoD,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             MtoC,
  output logic             DtoC,
  output logic             DivZero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2*WIDTH-1:0]   acc_q;    // mul: product; div: {remainder, dividend/quotient}
  logic [2*WIDTH-1:0]   mcand_q;  // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]     b_q;      // mul: multiplier shifted right; div: divisor magnitude
  logic                 sign_a_q, sign_b_q, is_div_q;
  logic                 mtoc_q, dtoc_q, divzero_q, busy_q;
  logic [WIDTH-1:0]     hi_q, lo_q;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quot_fixed, rem_fixed;
  logic [2*WIDTH-1:0]   div_step_d;
  logic [WIDTH:0]       div_top;
  logic [WIDTH-1:0]     div_sub;
  logic                 div_ge;
  logic                 mul_exit;

  mult_div_unit_sign_fix #(.Width(WIDTH)) u_abs_a (
    .val_i(A), .neg_i(A[WIDTH-1]), .val_o(a_abs)
  );
  mult_div_unit_sign_fix #(.Width(WIDTH)) u_abs_b (
    .val_i(B), .neg_i(B[WIDTH-1]), .val_o(b_abs)
  );
  mult_div_unit_sign_fix #(.Width(2*WIDTH)) u_fix_prod (
    .val_i(acc_q), .neg_i(sign_a_q ^ sign_b_q), .val_o(prod_fixed)
  );
  mult_div_unit_sign_fix #(.Width(WIDTH)) u_fix_quot (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(sign_a_q ^ sign_b_q), .val_o(quot_fixed)
  );
  // Remainder follows the dividend's sign.
  mult_div_unit_sign_fix #(.Width(WIDTH)) u_fix_rem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(sign_a_q), .val_o(rem_fixed)
  );

  // One restoring-divide step: shift {rem, dividend} left, trial-subtract divisor.
  always_comb begin
    div_top    = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge     = div_top >= {1'b0, b_q};
    div_sub    = div_top[WIDTH-1:0] - b_q;
    div_step_d = {(div_ge ? div_sub : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
  end

`ifdef MDU_EARLY_EXIT_EN
  // At least one step must have run so the minimum latency stays at three.
  assign mul_exit = (cnt_q == '0) || ((b_q == '0) && (cnt_q != CntW'(WIDTH)));
`else
  assign mul_exit = (cnt_q == '0);
`endif

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      b_q       <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_div_q  <= 1'b0;
      mtoc_q    <= 1'b0;
      dtoc_q    <= 1'b0;
      divzero_q <= 1'b0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      mtoc_q    <= 1'b0;
      dtoc_q    <= 1'b0;
      divzero_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          busy_q <= CtoD | CtoM;
          if (CtoD | CtoM) begin
            sign_a_q <= A[WIDTH-1];
            sign_b_q <= B[WIDTH-1];
            b_q      <= b_abs;
            cnt_q    <= CntW'(WIDTH);
            is_div_q <= CtoD;
          end
          if (CtoD) begin
            acc_q   <= {{WIDTH{1'b0}}, a_abs};
            state_q <= (B == '0) ? StDz : StDiv;
          end else if (CtoM) begin
            acc_q   <= '0;
            mcand_q <= {{WIDTH{1'b0}}, a_abs};
            state_q <= StMul;
          end
        end
        StMul: begin
          if (mul_exit) begin
            state_q <= StFix;
          end else begin
            if (b_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
            b_q     <= {1'b0, b_q[WIDTH-1:1]};
            cnt_q   <= cnt_q - CntW'(1);
          end
        end
        StDiv: begin
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            acc_q <= div_step_d;
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StDz: begin
          dtoc_q    <= 1'b1;
          divzero_q <= 1'b1;
          state_q   <= StIdle;
        end
        StFix: begin
          if (is_div_q) begin
            hi_q   <= rem_fixed;
            lo_q   <= quot_fixed;
            dtoc_q <= 1'b1;
          end else begin
            hi_q   <= prod_fixed[2*WIDTH-1:WIDTH];
            lo_q   <= prod_fixed[WIDTH-1:0];
            mtoc_q <= 1'b1;
          end
          state_q <= StDone;
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign MtoC    = mtoc_q;
  assign DtoC    = dtoc_q;
  assign DivZero = divzero_q;
  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: table of operations plus hand-written multi-cycle sequences.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        Reset;
  logic        CtoM, CtoD;
  logic [31:0] A, B;
  logic        MtoC, DtoC, DivZero, busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .Reset(Reset), .CtoM(CtoM), .CtoD(CtoD), .A(A), .B(B),
    .MtoC(MtoC), .DtoC(DtoC), .DivZero(DivZero), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        exp_d;  // 1: DtoC expected, 0: MtoC expected
    int          lat;    // edges after the start edge until the done pulse is visible
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] h, output logic [31:0] l,
                       output logic dz, output logic gm, output logic gd,
                       output logic busy_ok, output logic post_ok);
    @(negedge clock);
    A = a; B = b; CtoM = sm; CtoD = sd;
    @(posedge clock); #1;
    CtoM = 1'b0; CtoD = 1'b0;
    lat = 0;
    busy_ok = busy;
    while (!(MtoC || DtoC) && lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
    end
    h = hi; l = lo; dz = DivZero; gm = MtoC; gd = DtoC;
    @(posedge clock); #1;
    post_ok = !MtoC && !DtoC && !DivZero && !busy && (hi === h) && (lo === l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] h, l;
    logic        dz, gm, gd, bok, pok, spurious;
    int          gap;

    //      sm    sd    a             b             hi            lo            dz    d     lat
    vecs.push_back('{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, 34});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, 34});
    // Divide by zero: hi/lo keep the previous row's results.
    vecs.push_back('{1'b0, 1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b1, 1});
    // Both requests together: divide wins; overflow case wraps.
    vecs.push_back('{1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 34});
    vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 34});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 34});
    vecs.push_back('{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 34});
    vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0, 34});
    vecs.push_back('{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b1, 34});
    vecs.push_back('{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 1'b1, 34});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 1'b1, 34});
    vecs.push_back('{1'b1, 1'b0, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b0, 34});
    vecs.push_back('{1'b0, 1'b1, 32'd3,        32'd10,       32'd3,        32'd0,        1'b0, 1'b1, 34});

    Reset = 1'b0; CtoM = 1'b0; CtoD = 1'b0; A = '0; B = '0;
    #12;
    chk("reset_outs", {MtoC, DtoC, DivZero, busy}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    Reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].sm, vecs[i].sd, vecs[i].a, vecs[i].b, lat, h, l, dz, gm, gd, bok, pok);
`ifdef MDU_EARLY_EXIT_EN
      if (vecs[i].exp_d) chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      else chk($sformatf("v%0d_lat_range", i), 64'(lat >= 3 && lat <= 34), 64'd1);
`else
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
`endif
      chk($sformatf("v%0d_kind", i), {gm, gd}, {!vecs[i].exp_d, vecs[i].exp_d});
      chk($sformatf("v%0d_divzero", i), 64'(dz), 64'(vecs[i].dz));
      chk($sformatf("v%0d_hi", i), 64'(h), 64'(vecs[i].hi));
      chk($sformatf("v%0d_lo", i), 64'(l), 64'(vecs[i].lo));
      chk($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
      chk($sformatf("v%0d_post", i), 64'(pok), 64'd1);
    end

    // Held multiply request restarts straight after DONE.
    @(negedge clock);
    A = 32'd3; B = 32'h40000005; CtoM = 1'b1;
    @(posedge clock); #1;
    lat = 0;
    while (!MtoC && lat < 200) begin @(posedge clock); #1; lat++; end
    chk("held_first_lo", {hi, lo}, 64'h00000000_C000000F);
    gap = 0;
    @(posedge clock); #1; gap++;
    while (!MtoC && gap < 200) begin @(posedge clock); #1; gap++; end
    CtoM = 1'b0;
    chk("held_second", 64'(MtoC), 64'd1);
`ifndef MDU_EARLY_EXIT_EN
    chk("held_gap", 64'(gap), 64'd36);
`endif
    chk("held_second_lo", {hi, lo}, 64'h00000000_C000000F);
    repeat (3) @(posedge clock);

    // Mid-operation: CtoD ignored, then reset aborts with no done pulse.
    @(negedge clock);
    A = 32'd3; B = 32'h40000005; CtoM = 1'b1;
    @(posedge clock); #1;
    CtoM = 1'b0;
    spurious = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clock);
      CtoD = (i == 10);
      @(posedge clock); #1;
      if (MtoC || DtoC || DivZero || !busy) spurious = 1'b1;
    end
    CtoD = 1'b0;
    chk("ignore_ctod", 64'(spurious), 64'd0);
    @(negedge clock);
    Reset = 1'b0;
    #1;
    chk("abort_outs", {MtoC, DtoC, DivZero, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clock);
    Reset = 1'b1;
    spurious = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (MtoC || DtoC || busy) spurious = 1'b1;
    end
    chk("abort_no_done", 64'(spurious), 64'd0);

`ifdef MDU_EARLY_EXIT_EN
    do_op(1'b1, 1'b0, 32'h12345678, 32'd1, lat, h, l, dz, gm, gd, bok, pok);
    chk("early_lat", 64'(lat), 64'd3);
    chk("early_hilo", {h, l}, 64'h00000000_12345678);
    chk("early_kind", {gm, gd}, 64'b10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
